// File: rtl/op_seq_pkg.sv
// Shared types and helpers for the op_sequencer block.
package op_seq_pkg;

    typedef enum logic [2:0] {
        ENTER     = 3'd0,
        ENTER_REL = 3'd1,
        COMPUTE   = 3'd2,
        DISP      = 3'd3,
        DISP_REL  = 3'd4
    } seq_state_t;

    // Width of the shared operand/result index: clog2 of the larger count, never below 1 bit.
    function automatic int unsigned idx_width(input int unsigned n_ops, input int unsigned n_res);
        int unsigned m;
        m = (n_ops > n_res) ? n_ops : n_res;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/op_sequencer_if.sv
// Board/datapath-facing bundle of op_sequencer.
// master: the sequencer; slave: switches, LEDs and the datapath.
interface op_sequencer_if #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned N_OPS  = 4,
    parameter int unsigned N_RES  = 2,
    parameter int unsigned IDX_W  = op_seq_pkg::idx_width(N_OPS, N_RES)
);
    logic                      handshake;
    logic [WORD_W-1:0]         data_in;
    logic [N_OPS*WORD_W-1:0]   operands;
    logic                      start;
    logic                      res_valid;
    logic [N_RES*WORD_W-1:0]   results;
    logic [WORD_W-1:0]         led;
    logic [IDX_W-1:0]          idx;
    logic                      err;

    modport master (
        input  handshake, data_in, res_valid, results,
        output operands, start, led, idx, err
    );

    modport slave (
        output handshake, data_in, res_valid, results,
        input  operands, start, led, idx, err
    );
endinterface

// File: rtl/op_sequencer_hs_edge.sv
// Handshake edge detector with optional 2-flop input synchroniser.
// Macro OP_SEQUENCER_SYNC_EN: when defined, handshake and data pass through two flops first.
module hs_edge #(
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_hs,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_rise,
    output logic              o_fall,
    output logic [WORD_W-1:0] o_data
);
    logic w_hs;
    logic r_hs_q;

`ifdef OP_SEQUENCER_SYNC_EN
    logic [1:0]        r_hs_sync;
    logic [WORD_W-1:0] r_data_s1;
    logic [WORD_W-1:0] r_data_s2;

    // Two-stage synchroniser; data is delayed alongside the handshake so they stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_sync <= 2'b00;
            r_data_s1 <= '0;
            r_data_s2 <= '0;
        end else begin
            r_hs_sync <= {r_hs_sync[0], i_hs};
            r_data_s1 <= i_data;
            r_data_s2 <= r_data_s1;
        end
    end

    assign w_hs   = r_hs_sync[1];
    assign o_data = r_data_s2;
`else
    assign w_hs   = i_hs;
    assign o_data = i_data;
`endif

    // Previous handshake sample for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_hs_q <= 1'b0;
        else       r_hs_q <= w_hs;
    end

    assign o_rise = w_hs & ~r_hs_q;
    assign o_fall = ~w_hs & r_hs_q;
endmodule

// File: rtl/op_sequencer.sv
// Operand-entry / compute / result-display sequencer for the switch+LED front end.
// Macro OP_SEQUENCER_SYNC_EN (see hs_edge) adds a 2-cycle input synchroniser.
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned N_OPS   = 4,
    parameter int unsigned N_RES   = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic           clk,
    input logic           reset,
    op_sequencer_if.master bus
);
    localparam int unsigned IDX_W = idx_width(N_OPS, N_RES);
    localparam int unsigned WD_W  = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_OP  = IDX_W'(N_OPS - 1);
    localparam logic [IDX_W-1:0] LAST_RES = IDX_W'(N_RES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    seq_state_t              r_state, w_state_d;
    logic [IDX_W-1:0]        r_idx, w_idx_d;
    logic [N_OPS*WORD_W-1:0] r_ops, w_ops_d;
    logic [WD_W-1:0]         r_wdog, w_wdog_d;
    logic                    r_err, w_err_d;
    logic                    r_start, w_start_d;
    logic [WORD_W-1:0]       r_led, w_led_d;

    logic                    w_rise, w_fall;
    logic [WORD_W-1:0]       w_data;

    hs_edge #(.WORD_W(WORD_W)) u_hs_edge (
        .clk    (clk),
        .reset  (reset),
        .i_hs   (bus.handshake),
        .i_data (bus.data_in),
        .o_rise (w_rise),
        .o_fall (w_fall),
        .o_data (w_data)
    );

    // Next-state logic: one edge moves at most one state; edges in COMPUTE are ignored.
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_ops_d   = r_ops;
        w_wdog_d  = r_wdog;
        w_err_d   = r_err;
        w_start_d = 1'b0;
        case (r_state)
            ENTER: begin
                if (w_rise) begin
                    w_ops_d[int'(r_idx)*WORD_W +: WORD_W] = w_data;
                    w_err_d   = 1'b0;
                    w_state_d = ENTER_REL;
                end
            end
            ENTER_REL: begin
                if (w_fall) begin
                    if (r_idx == LAST_OP) begin
                        w_idx_d   = '0;
                        w_start_d = 1'b1;
                        w_wdog_d  = '0;
                        w_state_d = COMPUTE;
                    end else begin
                        w_idx_d   = r_idx + IDX_W'(1);
                        w_state_d = ENTER;
                    end
                end
            end
            COMPUTE: begin
                // A result arriving on the expiry cycle still wins over the timeout.
                if (bus.res_valid) begin
                    w_idx_d   = '0;
                    w_wdog_d  = '0;
                    w_state_d = DISP;
                end else if (r_wdog == WD_LAST) begin
                    w_err_d   = 1'b1;
                    w_idx_d   = '0;
                    w_wdog_d  = '0;
                    w_state_d = ENTER;
                end else begin
                    w_wdog_d  = r_wdog + WD_W'(1);
                end
            end
            DISP: begin
                if (w_rise) w_state_d = DISP_REL;
            end
            DISP_REL: begin
                if (w_fall) begin
                    if (r_idx == LAST_RES) begin
                        w_idx_d   = '0;
                        w_state_d = ENTER;
                    end else begin
                        w_idx_d   = r_idx + IDX_W'(1);
                        w_state_d = DISP;
                    end
                end
            end
            default: begin
                w_idx_d   = '0;
                w_state_d = ENTER;
            end
        endcase
    end

    // LED register is loaded from the next state so it is valid on the first DISP cycle.
    always_comb begin
        w_led_d = '0;
        if (w_state_d == DISP || w_state_d == DISP_REL) begin
            w_led_d = bus.results[int'(w_idx_d)*WORD_W +: WORD_W];
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ENTER;
            r_idx   <= '0;
            r_ops   <= '0;
            r_wdog  <= '0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_led   <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_ops   <= w_ops_d;
            r_wdog  <= w_wdog_d;
            r_err   <= w_err_d;
            r_start <= w_start_d;
            r_led   <= w_led_d;
        end
    end

    assign bus.operands = r_ops;
    assign bus.start    = r_start;
    assign bus.led      = r_led;
    assign bus.idx      = r_idx;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer (WORD_W=8, N_OPS=4, N_RES=2, TIMEOUT=16).
`timescale 1ns/1ps
module tb_op_sequencer;
    localparam int unsigned WORD_W  = 8;
    localparam int unsigned N_OPS   = 4;
    localparam int unsigned N_RES   = 2;
    localparam int unsigned TIMEOUT = 16;
`ifdef OP_SEQUENCER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   start_cnt = 0;
    logic [7:0] ops_m [N_OPS];

    op_sequencer_if #(.WORD_W(WORD_W), .N_OPS(N_OPS), .N_RES(N_RES)) bus ();

    op_sequencer #(.WORD_W(WORD_W), .N_OPS(N_OPS), .N_RES(N_RES), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (bus.start === 1'b1) start_cnt++;

    function automatic logic [31:0] exp_ops();
        logic [31:0] v;
        for (int k = 0; k < int'(N_OPS); k++) v[k*8 +: 8] = ops_m[k];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        bus.handshake = 1'b0; bus.data_in = '0; bus.res_valid = 1'b0; bus.results = '0;
        for (int k = 0; k < int'(N_OPS); k++) ops_m[k] = 8'h00;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    // One operand-entry pulse: checks the slot is untouched until the latch edge, then latched.
    task automatic enter_operand(input logic [7:0] d, input int k, input int hi, input int lo,
                                 input bit last);
        bus.handshake = 1'b1; bus.data_in = d;
        tick(LAT);
        checks++;
        if (bus.operands[k*8 +: 8] !== ops_m[k]) begin
            failures++; $display("FAIL pre_latch[%0d]: got %h want %h", k, bus.operands[k*8 +: 8], ops_m[k]);
        end
        tick(1);
        ops_m[k] = d;
        checks++;
        if (bus.operands !== exp_ops() || bus.idx !== 2'(k)) begin
            failures++; $display("FAIL latch[%0d]: ops=%h idx=%0d want ops=%h idx=%0d", k, bus.operands, bus.idx, exp_ops(), k);
        end
        tick(hi - 1);
        bus.handshake = 1'b0; bus.data_in = 8'($urandom);
        if (!last) begin
            tick(lo);
            checks++;
            if (bus.idx !== 2'(k + 1)) begin
                failures++; $display("FAIL idx_adv[%0d]: got %0d want %0d", k, bus.idx, k + 1);
            end
        end
    endtask

    // Returns on the negedge of the first COMPUTE cycle (start visible).
    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 8 + LAT; i++) begin
            @(negedge clk);
            if (bus.start === 1'b1) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL %s_start: got no start pulse want one", name); end
    endtask

    task automatic hs_pulse();
        bus.handshake = 1'b1; tick(LAT + 2);
        bus.handshake = 1'b0; tick(LAT + 2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.handshake = 1'b0; bus.data_in = '0; bus.res_valid = 1'b0; bus.results = '0;
        tick(3);
        checks++;
        if (bus.operands !== '0 || bus.start !== 1'b0 || bus.led !== '0 || bus.idx !== '0 || bus.err !== 1'b0) begin
            failures++; $display("FAIL reset: ops=%h start=%b led=%h idx=%0d err=%b want all 0",
                                 bus.operands, bus.start, bus.led, bus.idx, bus.err);
        end
        reset = 1'b0;
        for (int k = 0; k < int'(N_OPS); k++) ops_m[k] = 8'h00;
        tick(1);
    endtask

    task automatic test_full();
        int s0;
        reset_dut();
        s0 = start_cnt;
        for (int k = 0; k < 4; k++) enter_operand(8'(8'h11 * (k + 1)), k, 2, LAT + 2, k == 3);
        wait_start("full");
        checks++;
        if (bus.operands !== 32'h44332211) begin
            failures++; $display("FAIL full_ops: got %h want 44332211", bus.operands);
        end
        bus.results = 16'hBBAA; bus.res_valid = 1'b1;
        tick(1);
        bus.res_valid = 1'b0;
        checks++;
        if (bus.led !== 8'hAA || bus.idx !== 2'd0 || bus.start !== 1'b0) begin
            failures++; $display("FAIL full_disp0: led=%h idx=%0d start=%b want AA 0 0", bus.led, bus.idx, bus.start);
        end
        hs_pulse();
        checks++;
        if (bus.led !== 8'hBB || bus.idx !== 2'd1) begin
            failures++; $display("FAIL full_disp1: led=%h idx=%0d want BB 1", bus.led, bus.idx);
        end
        bus.results = 16'h77CC;
        tick(1);
        checks++;
        if (bus.led !== 8'h77) begin
            failures++; $display("FAIL full_track: led=%h want 77", bus.led);
        end
        hs_pulse();
        checks++;
        if (bus.led !== 8'h00 || bus.idx !== 2'd0 || start_cnt - s0 != 1) begin
            failures++; $display("FAIL full_end: led=%h idx=%0d starts=%0d want 00 0 1", bus.led, bus.idx, start_cnt - s0);
        end
        enter_operand(8'h5A, 0, 1, LAT + 1, 1'b0);
    endtask

    task automatic test_watchdog();
        reset_dut();
        for (int k = 0; k < 4; k++) enter_operand(8'($urandom_range(1, 255)), k, 1, LAT + 1, k == 3);
        wait_start("wdog");
        tick(TIMEOUT - 1);
        checks++;
        if (bus.err !== 1'b0) begin failures++; $display("FAIL wdog_early: err=%b want 0", bus.err); end
        tick(1);
        checks++;
        if (bus.err !== 1'b1 || bus.idx !== 2'd0 || bus.operands !== exp_ops() || bus.led !== '0) begin
            failures++; $display("FAIL wdog_expire: err=%b idx=%0d ops=%h led=%h want 1 0 %h 00",
                                 bus.err, bus.idx, bus.operands, bus.led, exp_ops());
        end
        enter_operand(8'hC3, 0, 2, LAT + 1, 1'b0);
        checks++;
        if (bus.err !== 1'b0) begin failures++; $display("FAIL wdog_clear: err=%b want 0", bus.err); end
    endtask

    task automatic test_boundary();
        logic [15:0] r;
        reset_dut();
        r = 16'($urandom);
        for (int k = 0; k < 4; k++) enter_operand(8'($urandom), k, 1, LAT + 1, k == 3);
        wait_start("bound");
        tick(TIMEOUT - 1);
        bus.results = r; bus.res_valid = 1'b1;
        tick(1);
        bus.res_valid = 1'b0;
        checks++;
        if (bus.err !== 1'b0 || bus.led !== r[7:0] || bus.idx !== 2'd0) begin
            failures++; $display("FAIL boundary: err=%b led=%h idx=%0d want 0 %h 0", bus.err, bus.led, bus.idx, r[7:0]);
        end
        hs_pulse(); hs_pulse();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        enter_operand(8'($urandom_range(1, 255)), 0, 1, LAT + 1, 1'b0);
        enter_operand(8'($urandom_range(1, 255)), 1, 1, LAT + 1, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.operands !== '0 || bus.idx !== '0 || bus.led !== '0 || bus.err !== 1'b0 || bus.start !== 1'b0) begin
            failures++; $display("FAIL reset_mid: ops=%h idx=%0d led=%h err=%b start=%b want all 0",
                                 bus.operands, bus.idx, bus.led, bus.err, bus.start);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < int'(N_OPS); k++) ops_m[k] = 8'h00;
        tick(1);
        enter_operand(8'h3C, 0, 1, LAT + 1, 1'b0);
    endtask

    task automatic test_glitch();
        reset_dut();
        bus.handshake = 1'b1; bus.data_in = 8'h96;
        tick(5);
        bus.data_in = 8'h69;
        tick(45);
        ops_m[0] = 8'h96;
        checks++;
        if (bus.operands !== exp_ops() || bus.idx !== 2'd0) begin
            failures++; $display("FAIL glitch_hold: ops=%h idx=%0d want %h 0", bus.operands, bus.idx, exp_ops());
        end
        bus.handshake = 1'b0;
        tick(LAT + 2);
        for (int k = 1; k < 4; k++) enter_operand(8'($urandom), k, 1, LAT + 1, k == 3);
        wait_start("glitch");
        for (int i = 0; i < 4; i++) begin
            bus.handshake = 1'b1; tick(1);
            bus.handshake = 1'b0; tick(1);
        end
        tick(TIMEOUT - 1 - 8);
        checks++;
        if (bus.err !== 1'b0 || bus.idx !== 2'd0) begin
            failures++; $display("FAIL glitch_compute: err=%b idx=%0d want 0 0", bus.err, bus.idx);
        end
        tick(1);
        checks++;
        if (bus.err !== 1'b1 || bus.operands !== exp_ops()) begin
            failures++; $display("FAIL glitch_expire: err=%b ops=%h want 1 %h", bus.err, bus.operands, exp_ops());
        end
    endtask

    // Randomised transactions against a transaction-level model.
    task automatic test_random();
        bit          err_m = 1'b0;
        logic [15:0] r;
        int          d;
        reset_dut();
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 4; k++) begin
                enter_operand(8'($urandom), k, $urandom_range(1, 4), LAT + $urandom_range(1, 4), k == 3);
                if (k == 0) begin
                    err_m = 1'b0;
                    checks++;
                    if (bus.err !== err_m) begin failures++; $display("FAIL rnd_err_clr[%0d]: err=%b want 0", t, bus.err); end
                end
            end
            wait_start("rnd");
            r = 16'($urandom);
            bus.results = r;
            d = $urandom_range(0, 20);
            tick(d);
            bus.res_valid = 1'b1;
            tick(1);
            bus.res_valid = 1'b0;
            if (d < int'(TIMEOUT)) begin
                checks++;
                if (bus.led !== r[7:0] || bus.err !== 1'b0) begin
                    failures++; $display("FAIL rnd_disp0[%0d]: led=%h err=%b want %h 0", t, bus.led, bus.err, r[7:0]);
                end
                hs_pulse();
                checks++;
                if (bus.led !== r[15:8] || bus.idx !== 2'd1) begin
                    failures++; $display("FAIL rnd_disp1[%0d]: led=%h idx=%0d want %h 1", t, bus.led, bus.idx, r[15:8]);
                end
                hs_pulse();
                checks++;
                if (bus.led !== 8'h00 || bus.idx !== 2'd0) begin
                    failures++; $display("FAIL rnd_end[%0d]: led=%h idx=%0d want 00 0", t, bus.led, bus.idx);
                end
            end else begin
                err_m = 1'b1;
                checks++;
                if (bus.err !== err_m || bus.led !== 8'h00 || bus.operands !== exp_ops()) begin
                    failures++; $display("FAIL rnd_timeout[%0d]: err=%b led=%h ops=%h want 1 00 %h",
                                         t, bus.err, bus.led, bus.operands, exp_ops());
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full();
        test_watchdog();
        test_boundary();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/op_sequencer.md
# op_sequencer

- Parametrised supervisory sequencer for the switch/LED front end of the arithmetic datapath (complex multiplier and successors).
- Collects `N_OPS` operand words from the switch bank, one per handshake cycle, and launches the datapath with a start pulse.
- Waits for a result-valid response under a watchdog, then steps `N_RES` result words onto the LEDs.
- Sits between the board I/O and the datapath, replacing fixed-count, fixed-width sequencing.

## Interface
Parameters:
- `WORD_W`, 16, width of each operand/result word and of the LED bus
- `N_OPS`, 4, number of operands collected per transaction (≥1)
- `N_RES`, 2, number of result words displayed per transaction (≥1)
- `TIMEOUT`, 1024, clock cycles allowed in COMPUTE before abort (≥2)

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `handshake`  in  1  user handshake switch
- `data_in`  in  `WORD_W`  operand value from switches
- `operands`  out  `N_OPS*WORD_W`  latched operands; operand k at bits [k*WORD_W +: WORD_W]
- `start`  out  1  one-cycle pulse launching the datapath
- `res_valid`  in  1  datapath result ready, level
- `results`  in  `N_RES*WORD_W`  datapath results, same packing as `operands`
- `led`  out  `WORD_W`  displayed word
- `idx`  out  `$clog2(max(N_OPS,N_RES,2))`  current operand/result index
- `err`  out  1  sticky watchdog-timeout flag

## Operation
- `handshake` is registered into `hs_q`.
  - `hs_rise = hs & !hs_q`
  - `hs_fall = !hs & hs_q`
  - `hs`/`data_in` are the (optionally synchronised) samples.
- States:
  - ENTER: on `hs_rise`, `operands[idx] <= data_in`, go to ENTER_REL.
  - ENTER_REL: on `hs_fall`, if `idx==N_OPS-1` then `idx<=0`, `start<=1`, go to COMPUTE; else `idx++`, go to ENTER.
  - COMPUTE: watchdog counter counts from 0.
    - `res_valid` → go to DISP, `idx<=0`, counter cleared.
    - Counter reaches `TIMEOUT-1` without `res_valid` → `err<=1`, go to ENTER with `idx=0`; operands retained.
  - DISP: `led = results[idx]`; on `hs_rise` go to DISP_REL.
  - DISP_REL: `led = results[idx]`; on `hs_fall`, if `idx==N_RES-1` then `idx<=0`, go to ENTER; else `idx++`, go to DISP.
- `led` is 0 in ENTER, ENTER_REL and COMPUTE.
- `err` clears on the first `hs_rise` in ENTER after it was set. That rise also latches normally.
- A single edge advances at most one state. Edges in COMPUTE are ignored.
- `res_valid` outside COMPUTE is ignored.
- `res_valid` in the same cycle the watchdog expires counts as success.
- Reset mid-transaction abandons everything; partially entered operands are cleared.

## Timing
- Reset values: state ENTER, `idx` 0, `operands` all 0, `start` 0, `led` 0, `err` 0, `hs_q` 0.
- Without sync: `operands[idx]` updates at the first clk edge after `handshake` is sampled high following a low sample. `data_in` is captured at that same edge.
- `start` is high exactly the one cycle after the ENTER_REL→COMPUTE edge, i.e. the first cycle in COMPUTE.
- `res_valid` high on the first COMPUTE cycle is accepted: DISP in the next cycle.
- `led` is registered: it shows `results[idx]` from the first DISP cycle onward. It tracks `results` each cycle while in DISP/DISP_REL.
- Watchdog: with no `res_valid`, exactly `TIMEOUT` cycles are spent in COMPUTE.

## Configuration
- `OP_SEQUENCER_SYNC_EN`
  - Defined: `handshake` and `data_in` each pass through a 2-flop synchroniser before edge detection. All handshake-driven responses are 2 cycles later. Synchroniser flops reset to 0.
  - Undefined: inputs are used directly. Handshake and data are then assumed synchronous to `clk`.

## Structure
- `op_seq_pkg`: state enum `seq_state_t` (ENTER, ENTER_REL, COMPUTE, DISP, DISP_REL) and the `idx`-width helper function.
- Sub-module `hs_edge`: optional synchroniser (under the macro), `hs_q` register, `rise`/`fall` outputs and delayed `data` output.
- The top level holds the FSM, operand registers, watchdog and LED mux.

## Test plan
All scenarios use `WORD_W=8`, `N_OPS=4`, `N_RES=2`, `TIMEOUT=16`, macro undefined unless stated.
- Full transaction: enter 0x11, 0x22, 0x33, 0x44 with handshake pulses → `operands`=0x44332211, one `start` pulse. Then `res_valid`, `results`=0xBBAA → `led` 0xAA, then after one handshake pulse 0xBB, then 0 and ENTER.
- Watchdog: enter 4 operands, hold `res_valid`=0 → after exactly 16 COMPUTE cycles `err`=1, state ENTER, `idx`=0, operands unchanged. Next rise → `err`=0 and operand 0 latched.
- Boundary: `res_valid` asserted on the 16th COMPUTE cycle → DISP, `err` stays 0.
- Reset mid-entry: assert `reset` after 2 operands → all outputs 0 immediately (async), `idx`=0.
- Glitch rules: `handshake` held high for 50 cycles → exactly one operand latched. Handshake toggles during COMPUTE → no state change.
- With `OP_SEQUENCER_SYNC_EN` defined: repeat the full transaction → identical values, each latch 2 cycles later than without the macro.
